// File: rtl/execute_muldiv_pkg.sv
// Shared types and op-decode helpers for the execute-stage multiply/divide unit.
package execute_muldiv_pkg;

  typedef enum logic [3:0] {
    MDU_MUL    = 4'd0,
    MDU_MULH   = 4'd1,
    MDU_MULHSU = 4'd2,
    MDU_MULHU  = 4'd3,
    MDU_DIV    = 4'd4,
    MDU_DIVU   = 4'd5,
    MDU_REM    = 4'd6,
    MDU_REMU   = 4'd7,
    MDU_NOP    = 4'hF
  } mdu_op_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;

  // Bit i gives operand signedness for op encoding i.
  localparam logic [7:0] OP_A_SIGNED = 8'b0101_0111;
  localparam logic [7:0] OP_B_SIGNED = 8'b0101_0011;

  function automatic logic is_m_op(input logic [3:0] o);
    return !o[3];
  endfunction

  function automatic logic is_div(input logic [3:0] o);
    return o[3:2] == 2'b01;
  endfunction

  function automatic logic is_rem(input logic [3:0] o);
    return o[3:1] == 3'b011;
  endfunction

  function automatic logic a_signed(input logic [3:0] o);
    return OP_A_SIGNED[o[2:0]];
  endfunction

  function automatic logic b_signed(input logic [3:0] o);
    return OP_B_SIGNED[o[2:0]];
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle (32 or XLEN steps).
// Compiled only when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module mdu_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, quo, dsr, diff;
  logic [XLEN:0]   shifted;
  logic            ge;

  // quotient/remainder are the values after the current step; valid to capture when done.
  always_comb begin
    shifted   = {rem, quo[XLEN-1]};
    ge        = shifted >= {1'b0, dsr};
    diff      = shifted[XLEN-1:0] - dsr;
    remainder = ge ? diff : shifted[XLEN-1:0];
    quotient  = {quo[XLEN-2:0], ge};
  end

  assign done = (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dsr <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (start) begin
      // Word dividends are pre-aligned so their MSB is shifted out first.
      cnt <= word ? CW'(32) : CW'(XLEN);
      rem <= '0;
      quo <= word ? (dividend << (XLEN - 32)) : dividend;
      dsr <= divisor;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      rem <= remainder;
      quo <= quotient;
    end
  end
endmodule
`endif

// File: rtl/execute_muldiv.sv
// Multi-cycle RV64M/RV32M unit: shift-add multiplier (MUL_BITS per cycle) plus optional divider.
// Divider built only with MDU_DIV_EN defined; otherwise div ops early-out with result 0.
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  mdu_op_t         op,
  input  logic            word_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int P2 = 2 * XLEN;
  localparam int CW = $clog2(XLEN + 1);
  localparam int NX = XLEN / MUL_BITS;
  localparam int NW = 32 / MUL_BITS;

  function automatic logic [XLEN-1:0] fmt(input logic w, input logic [XLEN-1:0] x);
    fmt = x;
    if (w) for (int i = 32; i < XLEN; i++) fmt[i] = x[31];
  endfunction

  mdu_state_t      state, state_nxt;
  mdu_op_t         op_q;
  logic            word_q, neg_q;
  logic [CW-1:0]   cnt;
  logic [P2-1:0]   acc, mcand, acc_nxt, prod;
  logic [XLEN-1:0] mplier, mul_hi, mul_res;
  logic            word, a_sgn, b_sgn, sa, sb, eo, accept, mul_last;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, eo_val;
  logic            div_done;
  logic [XLEN-1:0] div_res;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    word  = (XLEN == 64) && word_op;
    a_sgn = a_signed(op);
    b_sgn = b_signed(op);
    a_ext = src_a;
    b_ext = src_b;
    if (word) begin
      for (int i = 32; i < XLEN; i++) begin
        a_ext[i] = a_sgn & src_a[31];
        b_ext[i] = b_sgn & src_b[31];
      end
    end
    sa    = a_sgn & a_ext[XLEN-1];
    sb    = b_sgn & b_ext[XLEN-1];
    mag_a = sa ? -a_ext : a_ext;
    mag_b = sb ? -b_ext : b_ext;
  end

`ifdef MDU_DIV_EN
  logic [XLEN-1:0] min_val, div_q, div_r;

  always_comb begin
    min_val = '0;
    min_val[XLEN-1] = 1'b1;
    if (word) for (int i = 31; i < XLEN; i++) min_val[i] = 1'b1;
    eo     = !is_m_op(op);
    eo_val = '0;
    if (is_div(op)) begin
      if (b_ext == '0) begin
        eo     = 1'b1;
        eo_val = is_rem(op) ? a_ext : {XLEN{1'b1}};
      end else if (a_sgn && a_ext == min_val && b_ext == {XLEN{1'b1}}) begin
        eo     = 1'b1;
        eo_val = is_rem(op) ? '0 : a_ext;
      end
    end
  end

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .start     (accept && is_div(op) && !eo),
    .word      (word),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign div_res = fmt(word_q, is_rem(op_q) ? (neg_q ? -div_r : div_r)
                                            : (neg_q ? -div_q : div_q));
`else
  always_comb begin
    eo     = !is_m_op(op) || is_div(op);
    eo_val = '0;
  end

  assign div_done = 1'b0;
  assign div_res  = '0;
`endif

  // Sign correction folds into the final step so DONE is entered at edge N.
  always_comb begin
    acc_nxt = acc + mcand * P2'(mplier[MUL_BITS-1:0]);
    prod    = neg_q ? -acc_nxt : acc_nxt;
    mul_hi  = prod[P2-1:XLEN];
    if (word_q) mul_hi = XLEN'(prod[63:32]);
    mul_res = fmt(word_q, (op_q == MDU_MUL) ? prod[XLEN-1:0] : mul_hi);
  end

  assign mul_last = (cnt == CW'(word_q ? NW - 1 : NX - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = eo ? DONE : (is_div(op) ? DIV : MUL);
      MUL:     if (mul_last) state_nxt = DONE;
      DIV:     if (div_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      op_q   <= MDU_MUL;
      word_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          op_q   <= op;
          word_q <= word;
          neg_q  <= is_rem(op) ? sa : (sa ^ sb);
          cnt    <= '0;
          acc    <= '0;
          mcand  <= P2'(mag_a);
          mplier <= mag_b;
          if (eo) result <= fmt(word, eo_val);
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt + CW'(1);
          if (mul_last) result <= mul_res;
        end
        DIV:     if (div_done) result <= div_res;
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (reset) accept |-> is_m_op(op));

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv (XLEN=64, MUL_BITS=4): vector table plus handshake corner cases.
module tb_execute_muldiv;
  import execute_muldiv_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready, word_op;
  logic            out_valid, out_ready, busy;
  mdu_op_t         op;
  logic [XLEN-1:0] src_a, src_b, result;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(XLEN), .MUL_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .word_op   (word_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // edges: clock edges after the accept edge until out_valid is seen.
  typedef struct {
    mdu_op_t     op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          edges;
  } vec_t;

  vec_t vt[17];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG3 = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] NEG6 = 64'hFFFF_FFFF_FFFF_FFFA;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input mdu_op_t o, input logic w, input logic [63:0] a, input logic [63:0] b);
    op = o; word_op = w; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; src_a = '0; src_b = '0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " idle after take"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic ok, seen;

    vt[0]  = '{MDU_MUL,    1'b0, 64'd7, NEG3, 64'hFFFF_FFFF_FFFF_FFEB, 16};
    vt[1]  = '{MDU_MULHU,  1'b0, ONES, 64'd2, 64'd1, 16};
    vt[2]  = '{MDU_MULH,   1'b0, ONES, ONES, 64'd0, 16};
    vt[3]  = '{MDU_MULHSU, 1'b0, ONES, 64'd2, ONES, 16};
    vt[4]  = '{MDU_MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 8};
    vt[5]  = '{MDU_MUL,    1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 16};
    vt[6]  = '{MDU_MULH,   1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 16};
    vt[7]  = '{MDU_MULHU,  1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 16};
    vt[8]  = '{MDU_MUL,    1'b1, 64'hDEAD_0000_0000_0003, 64'h1234_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFF7, 8};
    vt[9]  = '{MDU_MULHU,  1'b0, 64'h1_0000_0000, 64'h3_0000_0000, 64'd3, 16};
`ifdef MDU_DIV_EN
    vt[10] = '{MDU_DIV,  1'b0, 64'd20, NEG6, NEG3, 64};
    vt[11] = '{MDU_REM,  1'b0, 64'd20, NEG6, 64'd2, 64};
    vt[12] = '{MDU_DIV,  1'b1, 64'h8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 0};
    vt[13] = '{MDU_DIVU, 1'b0, 64'd5, 64'd0, ONES, 0};
    vt[14] = '{MDU_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 0};
    vt[15] = '{MDU_DIV,  1'b0, 64'd9, 64'd3, 64'd3, 64};
    vt[16] = '{MDU_DIVU, 1'b1, 64'h1_0000_0064, 64'd7, 64'd14, 32};
`else
    vt[10] = '{MDU_DIV,  1'b0, 64'd20, NEG6, 64'd0, 0};
    vt[11] = '{MDU_REM,  1'b0, 64'd20, NEG6, 64'd0, 0};
    vt[12] = '{MDU_DIV,  1'b1, 64'h8000_0000, ONES, 64'd0, 0};
    vt[13] = '{MDU_DIVU, 1'b0, 64'd5, 64'd0, 64'd0, 0};
    vt[14] = '{MDU_REMU, 1'b0, 64'd5, 64'd0, 64'd0, 0};
    vt[15] = '{MDU_DIV,  1'b0, 64'd9, 64'd3, 64'd0, 0};
    vt[16] = '{MDU_DIVU, 1'b1, 64'h1_0000_0064, 64'd7, 64'd0, 0};
`endif

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = MDU_MUL; word_op = 1'b0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {in_ready, out_valid, busy}, 3'b100);
    chk("reset result", result, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      issue(vt[i].op, vt[i].w, vt[i].a, vt[i].b);
      wait_done(lat);
      chk($sformatf("vec%0d %s edges", i, vt[i].op.name()), 64'(lat), 64'(vt[i].edges));
      chk($sformatf("vec%0d %s result", i, vt[i].op.name()), result, vt[i].res);
      consume($sformatf("vec%0d", i));
    end

    // Result held with out_ready low; a pending request must not be taken.
    issue(MDU_MUL, 1'b0, 64'd3, 64'd5);
    wait_done(lat);
    ok = 1'b1;
    op = MDU_MULHU; src_a = 64'd9; src_b = 64'd9; in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!(out_valid && !in_ready && busy && result == 64'd15)) ok = 1'b0;
    end
    in_valid = 1'b0;
    chk("hold 10 cycles", 64'(ok), 64'd1);
    chk("hold result", result, 64'd15);
    consume("hold");

    // Flush on the edge of multiplier step 5.
    issue(MDU_MUL, 1'b0, 64'd7, NEG3);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush to idle", {in_ready, out_valid, busy}, 3'b100);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush no out_valid", 64'(seen), 64'd0);

    // Flush alongside a request in IDLE: nothing accepted.
    op = MDU_MUL; word_op = 1'b0; src_a = 64'd2; src_b = 64'd2;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush blocks accept", {in_ready, out_valid, busy}, 3'b100);

    // Flush wins over out_ready in DONE.
    issue(MDU_MUL, 1'b1, 64'd2, 64'd3);
    wait_done(lat);
    chk("mulw 2*3 result", result, 64'd6);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush in done", {in_ready, out_valid, busy}, 3'b100);

    // Asynchronous reset in the middle of an iterative op.
`ifdef MDU_DIV_EN
    issue(MDU_DIV, 1'b0, 64'd100, 64'd7);
`else
    issue(MDU_MUL, 1'b0, 64'd100, 64'd7);
`endif
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async reset outputs", {in_ready, out_valid, busy}, 3'b100);
    chk("async reset result", result, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(MDU_MUL, 1'b0, 64'd7, NEG3);
    wait_done(lat);
    chk("post-reset mul edges", 64'(lat), 64'd16);
    chk("post-reset mul result", result, 64'hFFFF_FFFF_FFFF_FFEB);
    consume("post-reset");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
